// File: rtl/weight_bus_pkg.sv
// Shared weight-bus widths and the loader state encoding.
// PE-side address decoders import the same widths so both ends of the bus agree.
package weight_bus_pkg;

  localparam int WEIGHT_DATA_WIDTH = 16;
  localparam int WEIGHT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // Address of word `idx` in a load based at `base`; wraps silently at 2^32.
  function automatic logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr(
    input logic [WEIGHT_ADDR_WIDTH-1:0] base,
    input logic [WEIGHT_ADDR_WIDTH-1:0] idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/weight_stream_loader.sv
// Writer side of the broadcast weight bus: after a start pulse, turns a valid/ready host
// word stream into NUM_WORDS single-cycle writes at consecutive addresses from START_ADDR.
module weight_stream_loader
  import weight_bus_pkg::*;
#(
  parameter logic [WEIGHT_ADDR_WIDTH-1:0] START_ADDR = 32'd0,
  parameter int NUM_WORDS = 1024,
  parameter int WR_GAP    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [WEIGHT_DATA_WIDTH-1:0]       s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [WEIGHT_DATA_WIDTH-1:0]       weight_wr_data,
  output logic [WEIGHT_ADDR_WIDTH-1:0]       weight_wr_addr,
  output logic                               weight_wr_en,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_WORDS+1)-1:0]     wr_count
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] WORD_LIMIT = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WR_GAP);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  loader_state_t state_r;
  loader_state_t state_next_s;

  logic [CNT_W-1:0]             word_cnt_r;
  logic [CNT_W-1:0]             word_next_s;
  logic [GAP_W-1:0]             gap_cnt_r;
  logic [GAP_W-1:0]             gap_next_s;
  logic                         ready_r;
  logic                         ready_next_s;
  logic                         xfer_s;
  logic                         last_s;
  logic [WEIGHT_DATA_WIDTH-1:0] data_r;
  logic [WEIGHT_ADDR_WIDTH-1:0] addr_r;
  logic                         wr_en_r;
  logic                         busy_r;
  logic                         done_r;

  // Next-state, counter and handshake decode.
  always_comb begin
    state_next_s = state_r;
    word_next_s  = word_cnt_r;
    gap_next_s   = gap_cnt_r;
    ready_next_s = 1'b0;
    xfer_s       = (state_r == ST_LOAD) && s_valid && ready_r;
    last_s       = xfer_s && (word_cnt_r == LAST_IDX);

    if (gap_cnt_r != '0) begin
      gap_next_s = gap_cnt_r - GAP_ONE;
    end else begin
      gap_next_s = gap_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOAD;
          word_next_s  = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          word_next_s = word_cnt_r + CNT_ONE;
          gap_next_s  = GAP_RELOAD;
        end else begin
          word_next_s = word_cnt_r;
        end
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // s_ready is registered, so it is computed from the state we are about to enter.
    ready_next_s = (state_next_s == ST_LOAD) && (gap_next_s == '0) && (word_next_s < WORD_LIMIT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Counters and registered bus outputs; data/address hold while no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= '0;
      gap_cnt_r  <= '0;
      ready_r    <= 1'b0;
      data_r     <= '0;
      addr_r     <= '0;
      wr_en_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      word_cnt_r <= word_next_s;
      gap_cnt_r  <= gap_next_s;
      ready_r    <= ready_next_s;
      wr_en_r    <= xfer_s;
      done_r     <= last_s;
      busy_r     <= (state_next_s != ST_IDLE);
      if (xfer_s) begin
        data_r <= s_data;
        addr_r <= weight_addr(START_ADDR, WEIGHT_ADDR_WIDTH'(word_cnt_r));
      end else begin
        data_r <= data_r;
        addr_r <= addr_r;
      end
    end
  end

  assign s_ready        = ready_r;
  assign weight_wr_data = data_r;
  assign weight_wr_addr = addr_r;
  assign weight_wr_en   = wr_en_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign wr_count       = word_cnt_r;

endmodule

// File: tb/tb_weight_stream_loader.sv
// Self-checking bench: three loader configurations, a per-cycle vector table for the
// back-to-back configuration, and a write scoreboard fed at each accepted handshake.
module tb_weight_stream_loader;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    logic        done;
    int          cnt;
  } wr_exp_t;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_en;
    logic        exp_done;
    int          exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: START_ADDR=23, NUM_WORDS=4, WR_GAP=0
  logic        a_rst, a_start, a_valid, a_ready, a_wen, a_busy, a_done;
  logic [15:0] a_data, a_wdata;
  logic [31:0] a_waddr;
  logic [2:0]  a_cnt;
  // Instance B: START_ADDR=23, NUM_WORDS=4, WR_GAP=2
  logic        b_rst, b_start, b_valid, b_ready, b_wen, b_busy, b_done;
  logic [15:0] b_data, b_wdata;
  logic [31:0] b_waddr;
  logic [2:0]  b_cnt;
  // Instance C: START_ADDR=0xFFFF_FFF0, NUM_WORDS=1, WR_GAP=0
  logic        c_rst, c_start, c_valid, c_ready, c_wen, c_busy, c_done;
  logic [15:0] c_data, c_wdata;
  logic [31:0] c_waddr;
  logic [0:0]  c_cnt;

  weight_stream_loader #(.START_ADDR(32'd23), .NUM_WORDS(4), .WR_GAP(0)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .s_data(a_data), .s_valid(a_valid),
    .s_ready(a_ready), .weight_wr_data(a_wdata), .weight_wr_addr(a_waddr),
    .weight_wr_en(a_wen), .busy(a_busy), .done(a_done), .wr_count(a_cnt));

  weight_stream_loader #(.START_ADDR(32'd23), .NUM_WORDS(4), .WR_GAP(2)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_ready), .weight_wr_data(b_wdata), .weight_wr_addr(b_waddr),
    .weight_wr_en(b_wen), .busy(b_busy), .done(b_done), .wr_count(b_cnt));

  weight_stream_loader #(.START_ADDR(32'hFFFF_FFF0), .NUM_WORDS(1), .WR_GAP(0)) dut_c (
    .clk(clk), .rst(c_rst), .start(c_start), .s_data(c_data), .s_valid(c_valid),
    .s_ready(c_ready), .weight_wr_data(c_wdata), .weight_wr_addr(c_waddr),
    .weight_wr_en(c_wen), .busy(c_busy), .done(c_done), .wr_count(c_cnt));

  wr_exp_t qa[$];
  wr_exp_t qb[$];
  wr_exp_t qc[$];
  int a_idx = 0;
  int b_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic no_pending(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: strobe with no accepted word pending", name);
  endtask

  // Drive instance A for one cycle and record the write a handshake will cause.
  task automatic drive_a(input logic st, input logic vld, input logic [15:0] d);
    wr_exp_t e;
    a_start = st;
    a_valid = vld;
    a_data  = d;
    if (vld && (a_ready === 1'b1) && !a_rst) begin
      e.addr = 32'd23 + 32'(a_idx);
      e.data = d;
      e.done = (a_idx == 3);
      e.cnt  = a_idx + 1;
      qa.push_back(e);
      a_idx++;
    end
  endtask

  always @(negedge clk) begin
    wr_exp_t e;
    if (a_wen === 1'b1) begin
      if (qa.size() == 0) no_pending("a_strobe");
      else begin
        e = qa.pop_front();
        check("a_addr", 64'(a_waddr), 64'(e.addr));
        check("a_data", 64'(a_wdata), 64'(e.data));
        check("a_done", 64'(a_done), 64'(e.done));
        check("a_wr_count", 64'(a_cnt), 64'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    wr_exp_t e;
    if (b_wen === 1'b1) begin
      if (qb.size() == 0) no_pending("b_strobe");
      else begin
        e = qb.pop_front();
        check("b_addr", 64'(b_waddr), 64'(e.addr));
        check("b_data", 64'(b_wdata), 64'(e.data));
        check("b_done", 64'(b_done), 64'(e.done));
        check("b_wr_count", 64'(b_cnt), 64'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    wr_exp_t e;
    if (c_wen === 1'b1) begin
      if (qc.size() == 0) no_pending("c_strobe");
      else begin
        e = qc.pop_front();
        check("c_addr", 64'(c_waddr), 64'(e.addr));
        check("c_data", 64'(c_wdata), 64'(e.data));
        check("c_done", 64'(c_done), 64'(e.done));
        check("c_wr_count", 64'(c_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t    tv[$];
    wr_exp_t e;
    int      acc_cyc[$];
    int      stb_cyc[$];
    logic    ready_hist[0:31];

    // Back-to-back load, outputs expected during each cycle the row is applied.
    tv.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0});
    tv.push_back('{1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tv.push_back('{1'b0, 1'b1, 16'h0012, 1'b1, 1'b1, 1'b1, 1'b0, 1});
    tv.push_back('{1'b0, 1'b1, 16'h0013, 1'b1, 1'b1, 1'b1, 1'b0, 2});
    tv.push_back('{1'b0, 1'b1, 16'h0014, 1'b1, 1'b1, 1'b1, 1'b0, 3});
    tv.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 4});
    tv.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    // s_valid pattern 1,0,0,1,...
    tv.push_back('{1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    tv.push_back('{1'b0, 1'b1, 16'h0031, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0, 1});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tv.push_back('{1'b0, 1'b1, 16'h0032, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0, 2});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0, 2});
    tv.push_back('{1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b0, 1'b0, 2});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0, 3});
    tv.push_back('{1'b0, 1'b1, 16'h0034, 1'b1, 1'b1, 1'b0, 1'b0, 3});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1, 4});
    tv.push_back('{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    // s_valid high before start; start re-pulsed in LOAD and in DONE
    tv.push_back('{1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    tv.push_back('{1'b0, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    tv.push_back('{1'b1, 1'b1, 16'h0021, 1'b0, 1'b0, 1'b0, 1'b0, 4});
    tv.push_back('{1'b0, 1'b1, 16'h0021, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    tv.push_back('{1'b1, 1'b1, 16'h0022, 1'b1, 1'b1, 1'b1, 1'b0, 1});
    tv.push_back('{1'b1, 1'b1, 16'h0023, 1'b1, 1'b1, 1'b1, 1'b0, 2});
    tv.push_back('{1'b0, 1'b1, 16'h0024, 1'b1, 1'b1, 1'b1, 1'b0, 3});
    tv.push_back('{1'b1, 1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 1'b1, 4});
    tv.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4});

    // Reset with start held high: reset must win.
    a_rst = 1'b1; a_start = 1'b1; a_valid = 1'b1; a_data = 16'h7777;
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 16'h0000;
    c_rst = 1'b1; c_start = 1'b0; c_valid = 1'b0; c_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(a_ready), 64'(1'b0));
    check("rst_wr_en", 64'(a_wen), 64'(1'b0));
    check("rst_wr_data", 64'(a_wdata), 64'(16'h0000));
    check("rst_wr_addr", 64'(a_waddr), 64'(32'h0));
    check("rst_busy", 64'(a_busy), 64'(1'b0));
    check("rst_done", 64'(a_done), 64'(1'b0));
    check("rst_wr_count", 64'(a_cnt), 64'(3'd0));
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_start = 1'b0; a_valid = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      check($sformatf("v%0d_ready", i), 64'(a_ready), 64'(tv[i].exp_ready));
      check($sformatf("v%0d_busy", i), 64'(a_busy), 64'(tv[i].exp_busy));
      check($sformatf("v%0d_wr_en", i), 64'(a_wen), 64'(tv[i].exp_en));
      check($sformatf("v%0d_done", i), 64'(a_done), 64'(tv[i].exp_done));
      check($sformatf("v%0d_wr_count", i), 64'(a_cnt), 64'(tv[i].exp_cnt));
      if (tv[i].start && !tv[i].exp_busy) a_idx = 0;
      drive_a(tv[i].start, tv[i].valid, tv[i].data);
    end

    // Reset after two of four writes, then a fresh load from the start address.
    @(negedge clk); a_idx = 0; drive_a(1'b1, 1'b0, 16'h0000);
    @(negedge clk); drive_a(1'b0, 1'b1, 16'h0041);
    @(negedge clk); drive_a(1'b0, 1'b1, 16'h0042);
    @(negedge clk); a_rst = 1'b1; drive_a(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("midrst_wr_en", 64'(a_wen), 64'(1'b0));
    check("midrst_busy", 64'(a_busy), 64'(1'b0));
    check("midrst_wr_count", 64'(a_cnt), 64'(3'd0));
    check("midrst_ready", 64'(a_ready), 64'(1'b0));
    check("midrst_done", 64'(a_done), 64'(1'b0));
    check("midrst_addr", 64'(a_waddr), 64'(32'h0));
    a_rst = 1'b0; a_idx = 0; drive_a(1'b1, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive_a(1'b0, 1'b1, 16'(16'h0051 + k));
    end
    @(negedge clk); drive_a(1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    check("reload_words_accepted", 64'(a_idx), 64'(4));
    check("reload_busy", 64'(a_busy), 64'(1'b0));
    check("reload_wr_count", 64'(a_cnt), 64'(3'd4));

    // WR_GAP=2 with s_valid held high.
    for (int k = 0; k < 32; k++) ready_hist[k] = 1'b0;
    @(negedge clk); b_idx = 0; b_start = 1'b1;
    for (int cyc = 1; cyc < 20; cyc++) begin
      @(negedge clk);
      b_start = 1'b0;
      ready_hist[cyc] = b_ready;
      if (b_wen === 1'b1) stb_cyc.push_back(cyc);
      b_valid = 1'b1;
      b_data  = 16'(16'h0011 + b_idx);
      if (b_ready === 1'b1) begin
        e.addr = 32'd23 + 32'(b_idx);
        e.data = b_data;
        e.done = (b_idx == 3);
        e.cnt  = b_idx + 1;
        qb.push_back(e);
        acc_cyc.push_back(cyc);
        b_idx++;
      end
    end
    b_valid = 1'b0;
    check("gap_accepts", 64'(acc_cyc.size()), 64'(4));
    check("gap_strobes", 64'(stb_cyc.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < acc_cyc.size() && k < stb_cyc.size())
        check($sformatf("gap_latency%0d", k), 64'(stb_cyc[k] - acc_cyc[k]), 64'(1));
      if (k > 0 && k < stb_cyc.size())
        check($sformatf("gap_spacing%0d", k), 64'(stb_cyc[k] - stb_cyc[k-1]), 64'(3));
      if (k < acc_cyc.size()) begin
        check($sformatf("gap_ready_low1_%0d", k), 64'(ready_hist[acc_cyc[k] + 1]), 64'(1'b0));
        check($sformatf("gap_ready_low2_%0d", k), 64'(ready_hist[acc_cyc[k] + 2]), 64'(1'b0));
      end
    end
    check("gap_busy_end", 64'(b_busy), 64'(1'b0));
    check("gap_wr_count_end", 64'(b_cnt), 64'(3'd4));

    // NUM_WORDS=1 at the top of the address space.
    @(negedge clk); c_start = 1'b1; c_valid = 1'b1; c_data = 16'hBEEF;
    @(negedge clk); c_start = 1'b0;
    check("one_ready", 64'(c_ready), 64'(1'b1));
    if (c_ready === 1'b1) begin
      e.addr = 32'hFFFF_FFF0; e.data = 16'hBEEF; e.done = 1'b1; e.cnt = 1;
      qc.push_back(e);
    end
    @(negedge clk); c_valid = 1'b0;
    check("one_strobe", 64'(c_wen), 64'(1'b1));
    check("one_busy_at_done", 64'(c_busy), 64'(1'b1));
    check("one_ready_after", 64'(c_ready), 64'(1'b0));
    @(negedge clk);
    check("one_idle_busy", 64'(c_busy), 64'(1'b0));
    check("one_idle_wr_en", 64'(c_wen), 64'(1'b0));
    c_start = 1'b1;
    @(negedge clk); c_start = 1'b0;
    check("one_restart_busy", 64'(c_busy), 64'(1'b1));
    check("one_restart_wr_count", 64'(c_cnt), 64'(1'b0));
    c_valid = 1'b1; c_data = 16'h1234;
    if (c_ready === 1'b1) begin
      e.addr = 32'hFFFF_FFF0; e.data = 16'h1234; e.done = 1'b1; e.cnt = 1;
      qc.push_back(e);
    end
    @(negedge clk); c_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("a_queue_drained", 64'(qa.size()), 64'(0));
    check("b_queue_drained", 64'(qb.size()), 64'(0));
    check("c_queue_drained", 64'(qc.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
